eq_band_scheduler: RTL and testbench

- Sequences the digital equalizer's single shared band-filter core across all bands for each received audio sample.
- Per sample it:
  - deserializes the 16-bit serial word framed by `SFS`,
  - dispatches the sample to the core once per band with a start/done handshake,
  - applies a programmable per-band gain and accumulates the results,
  - saturates the sum and presents it on `D_out` with per-band clip flags on `EQ_out`.
- Sits between the serial audio input (`SCK`/`SFS`/`D`/`LR`) and the band-filter core.

---
 rtl/eq_pkg.sv | 19 +
 rtl/eq_gain_regfile.sv | 44 ++++
 rtl/eq_band_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_eq_band_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared state encoding and arithmetic constants for the equalizer band scheduler.
package eq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DISPATCH,
    ST_WAIT,
    ST_ACC,
    ST_OUT
  } eq_state_e;

  localparam logic [7:0] UNITY_GAIN = 8'h80;

  localparam int ACC_W = 27;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/eq_gain_regfile.sv
// Per-band gain registers with a shadow copy frozen at each sample start,
// so gain writes during a sample only affect the next one.
module eq_gain_regfile
  import eq_pkg::*;
#(
  parameter int N_BANDS = 5,
  parameter int GAIN_W  = 8,
  parameter int BAND_W  = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [BAND_W-1:0]                addr,
  input  logic [GAIN_W-1:0]                wdata,
  input  logic                             snap,
  output logic [N_BANDS-1:0][GAIN_W-1:0]   live_o,
  output logic [N_BANDS-1:0][GAIN_W-1:0]   shadow_o
);

  logic [N_BANDS-1:0][GAIN_W-1:0] live_d, live_q;
  logic [N_BANDS-1:0][GAIN_W-1:0] shadow_d, shadow_q;

  always_comb begin
    live_d   = live_q;
    shadow_d = shadow_q;
    if (we && (int'(addr) < N_BANDS)) live_d[addr] = wdata;
    // Snapshot takes the pre-write value, so a same-cycle write misses this sample.
    if (snap) shadow_d = live_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= {N_BANDS{GAIN_W'(UNITY_GAIN)}};
      shadow_q <= {N_BANDS{GAIN_W'(UNITY_GAIN)}};
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
    end
  end

  assign live_o   = live_q;
  assign shadow_o = shadow_q;

endmodule

// File: rtl/eq_band_scheduler.sv
// Deserializes one audio sample, runs it through the shared band-filter core
// once per band, applies per-band gain, and outputs the saturated sum.
module eq_band_scheduler
  import eq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int N_BANDS = 5,
  parameter int GAIN_W  = 8,
  parameter int BAND_W  = 3
) (
  input  logic                           SCK,
  input  logic                           reset,
  input  logic                           SFS,
  input  logic                           D,
  input  logic                           LR,
  input  logic                           bypass,
  input  logic                           gain_we,
  input  logic [BAND_W-1:0]              gain_addr,
  input  logic [GAIN_W-1:0]              gain_data,
  output logic                           core_start,
  output logic [BAND_W-1:0]              core_band,
  output logic                           core_ch,
  output logic [DATA_W-1:0]              core_x,
  input  logic                           core_done,
  input  logic [DATA_W-1:0]              core_y,
  output logic [DATA_W-1:0]              D_out,
  output logic                           d_valid,
  output logic [N_BANDS-1:0]             EQ_out,
  output logic                           busy,
  output logic                           overrun,
  output eq_state_e                      state_dbg,
  output logic [N_BANDS-1:0][GAIN_W-1:0] gain_dbg
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int P_W   = DATA_W + GAIN_W;

  // Core handshake: core_start is high for exactly one cycle (the DISPATCH
  // state) with band/ch/x stable; the core answers later with a one-cycle
  // core_done carrying core_y, which is only honoured while in WAIT.

  eq_state_e                      state_d, state_q;
  logic [DATA_W-1:0]              shift_d, shift_q;
  logic [CNT_W-1:0]               cnt_d, cnt_q;
  logic                           lr_d, lr_q, byp_d, byp_q;
  logic [BAND_W-1:0]              band_d, band_q;
  logic [ACC_W-1:0]               acc_d, acc_q;
  logic [DATA_W-1:0]              y_d, y_q;
  logic [DATA_W-1:0]              d_out_d, d_out_q;
  logic [N_BANDS-1:0]             eq_d, eq_q;
  logic                           start_d, start_q, dv_d, dv_q;
  logic                           ovr_d, ovr_q, busy_d, busy_q;
  logic                           snap, begin_sample;
  logic [N_BANDS-1:0][GAIN_W-1:0] shadow;

  logic [DATA_W-1:0]              shifted;
  logic [P_W-1:0]                 y_ext, g_ext;
  logic signed [P_W-1:0]          prod, scaled;
  logic                           clip, out_fits;
  logic [ACC_W:0]                 acc_sum;
  logic [ACC_W-1:0]               acc_sat;
  logic [ACC_W-DATA_W:0]          out_hi;
  logic [DATA_W-1:0]              acc_out;

  eq_gain_regfile #(.N_BANDS(N_BANDS), .GAIN_W(GAIN_W), .BAND_W(BAND_W)) u_gains (
    .clk      (SCK),
    .rst_n    (reset),
    .we       (gain_we),
    .addr     (gain_addr),
    .wdata    (gain_data),
    .snap     (snap),
    .live_o   (gain_dbg),
    .shadow_o (shadow)
  );

  assign shifted = {shift_q[DATA_W-2:0], D};

  // Q1.7 gain: widen both operands so the product keeps its sign in P_W bits.
  assign y_ext   = {{GAIN_W{y_q[DATA_W-1]}}, y_q};
  assign g_ext   = {{DATA_W{1'b0}}, shadow[band_q]};
  assign prod    = $signed(y_ext * g_ext);
  assign scaled  = prod >>> (GAIN_W - 1);
  assign clip    = ~(&scaled[P_W-1:DATA_W-1] | ~|scaled[P_W-1:DATA_W-1]);
  assign acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-P_W){scaled[P_W-1]}}, scaled};
  assign acc_sat = (acc_sum[ACC_W] != acc_sum[ACC_W-1]) ?
                   (acc_sum[ACC_W] ? ACC_MIN : ACC_MAX) : acc_sum[ACC_W-1:0];
  assign out_hi   = acc_sat[ACC_W-1:DATA_W-1];
  assign out_fits = &out_hi | ~|out_hi;
  assign acc_out  = out_fits ? acc_sat[DATA_W-1:0] :
                    {acc_sat[ACC_W-1], {(DATA_W-1){~acc_sat[ACC_W-1]}}};

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    lr_d         = lr_q;
    byp_d        = byp_q;
    band_d       = band_q;
    acc_d        = acc_q;
    y_d          = y_q;
    d_out_d      = d_out_q;
    eq_d         = eq_q;
    start_d      = 1'b0;
    dv_d         = 1'b0;
    ovr_d        = 1'b0;
    begin_sample = 1'b0;
    unique case (state_q)
      ST_IDLE: begin_sample = SFS;
      ST_SHIFT: begin
        if (SFS) begin
          begin_sample = 1'b1;
          ovr_d        = 1'b1;
        end else begin
          shift_d = shifted;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            if (byp_q) begin
              state_d = ST_OUT;
              d_out_d = shifted;
              dv_d    = 1'b1;
            end else begin
              state_d = ST_DISPATCH;
              band_d  = '0;
              acc_d   = '0;
              start_d = 1'b1;
            end
          end
        end
      end
      ST_DISPATCH: begin
        ovr_d   = SFS;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ovr_d = SFS;
        if (core_done) begin
          y_d     = core_y;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        ovr_d        = SFS;
        eq_d[band_q] = clip;
        acc_d        = acc_sat;
        if (band_q == BAND_W'(N_BANDS-1)) begin
          state_d = ST_OUT;
          d_out_d = acc_out;
          dv_d    = 1'b1;
        end else begin
          band_d  = band_q + BAND_W'(1);
          state_d = ST_DISPATCH;
          start_d = 1'b1;
        end
      end
      ST_OUT: begin
        begin_sample = SFS;
        if (!SFS) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // An SFS inside SHIFT re-latches channel/bypass/gains as a fresh sample.
    if (begin_sample) begin
      state_d = ST_SHIFT;
      shift_d = shifted;
      cnt_d   = CNT_W'(1);
      lr_d    = LR;
      byp_d   = bypass;
      eq_d    = '0;
    end
    snap   = begin_sample;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge SCK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      lr_q    <= 1'b0;
      byp_q   <= 1'b0;
      band_q  <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      d_out_q <= '0;
      eq_q    <= '0;
      start_q <= 1'b0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
      byp_q   <= byp_d;
      band_q  <= band_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      d_out_q <= d_out_d;
      eq_q    <= eq_d;
      start_q <= start_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign core_start = start_q;
  assign core_band  = band_q;
  assign core_ch    = lr_q;
  assign core_x     = shift_q;
  assign D_out      = d_out_q;
  assign d_valid    = dv_q;
  assign EQ_out     = eq_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Bench for eq_band_scheduler: core stub, constant vector table, corner
// sequences, and randomized samples against an arithmetic reference model.
module tb_eq_band_scheduler;
  import eq_pkg::*;

  logic              SCK, reset, SFS, D, LR, bypass, gain_we;
  logic [2:0]        gain_addr;
  logic [7:0]        gain_data;
  logic              core_start, core_ch, core_done;
  logic [2:0]        core_band;
  logic [15:0]       core_x, core_y, D_out;
  logic              d_valid, busy, overrun;
  logic [4:0]        EQ_out;
  eq_state_e         state_dbg;
  logic [4:0][7:0]   gain_dbg;

  eq_band_scheduler dut (
    .SCK(SCK), .reset(reset), .SFS(SFS), .D(D), .LR(LR), .bypass(bypass),
    .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data),
    .core_start(core_start), .core_band(core_band), .core_ch(core_ch), .core_x(core_x),
    .core_done(core_done), .core_y(core_y), .D_out(D_out), .d_valid(d_valid),
    .EQ_out(EQ_out), .busy(busy), .overrun(overrun), .state_dbg(state_dbg),
    .gain_dbg(gain_dbg)
  );

  // ---- clock / reset ----
  initial begin
    SCK = 1'b0;
    forever #5 SCK = ~SCK;
  end

  int total = 0, bad = 0;
  int cyc = 0, k_cyc = 0;
  int dv_cnt = 0, ovr_cnt = 0;
  int stub_lat = 1;
  logic [15:0] stub_y [5];
  logic [7:0]  gain_m [5];
  logic [7:0]  shadow_m [5];
  logic [2:0]  exp_q [$];
  logic [2:0]  band_log [$];
  logic        ch_log [$];
  logic [15:0] x_log [$];

  always @(posedge SCK) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge SCK);
      #1;
      if (d_valid) dv_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  // Band-filter core stub: answers each start after stub_lat cycles.
  initial begin
    core_done = 1'b0;
    core_y    = '0;
    forever begin
      @(negedge SCK);
      core_done = 1'b0;
      if (core_start) begin
        logic [2:0] b;
        b = core_band;
        band_log.push_back(core_band);
        ch_log.push_back(core_ch);
        x_log.push_back(core_x);
        repeat (stub_lat - 1) @(negedge SCK);
        @(negedge SCK);
        core_done = 1'b1;
        core_y    = (b < 3'd5) ? stub_y[b] : 16'h0000;
      end
    end
  end

  // ---- scoreboard helpers ----
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [15:0] x, input logic byp,
                                output logic [15:0] dout, output logic [4:0] eq);
    longint acc;
    acc = 0;
    eq  = '0;
    dout = x;
    if (byp) return;
    for (int b = 0; b < 5; b++) begin
      longint p, s;
      p = longint'($signed(stub_y[b])) * longint'(shadow_m[b]);
      s = p >>> 7;
      if (s > 32767 || s < -32768) eq[b] = 1'b1;
      acc += s;
      if (acc > 67108863) acc = 67108863;
      if (acc < -67108864) acc = -67108864;
    end
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    dout = 16'(acc);
  endfunction

  function automatic logic [39:0] gains_packed();
    logic [39:0] g;
    for (int b = 0; b < 5; b++) g[b*8 +: 8] = gain_m[b];
    return g;
  endfunction

  // ---- driver tasks ----
  task automatic write_gain(input logic [2:0] addr, input logic [7:0] data);
    @(negedge SCK);
    gain_we = 1'b1; gain_addr = addr; gain_data = data;
    @(negedge SCK);
    gain_we = 1'b0;
    if (addr < 3'd5) gain_m[addr] = data;
  endtask

  task automatic send_bits(input logic [15:0] x, input int n, input logic lr, input logic byp);
    for (int i = 0; i < n; i++) begin
      @(negedge SCK);
      if (i == 0) begin
        SFS = 1'b1; LR = lr; bypass = byp; k_cyc = cyc + 1;
      end else begin
        SFS = 1'b0; LR = 1'b0; bypass = 1'b0;
      end
      D = x[15-i];
    end
    @(negedge SCK);
    SFS = 1'b0; D = 1'b0;
  endtask

  task automatic start_sample(input logic [15:0] x, input logic lr, input logic byp);
    for (int b = 0; b < 5; b++) shadow_m[b] = gain_m[b];
    band_log.delete(); ch_log.delete(); x_log.delete();
    send_bits(x, 16, lr, byp);
  endtask

  task automatic wait_result(output logic [15:0] d, output logic [4:0] eq, output int c);
    c = -1; d = '0; eq = '0;
    for (int i = 0; i < 300; i++) begin
      if (d_valid) begin
        c = cyc - k_cyc + 1; d = D_out; eq = EQ_out;
        break;
      end
      @(negedge SCK);
    end
    @(negedge SCK);
    check("dvalid_one_cycle", d_valid, 1'b0);
  endtask

  task automatic check_dispatch(input logic lr, input logic [15:0] x, input logic byp);
    int n_exp;
    bit ok;
    n_exp = byp ? 0 : 5;
    exp_q.delete();
    for (int b = 0; b < n_exp; b++) exp_q.push_back(3'(b));
    check("start_count", band_log.size(), n_exp);
    ok = 1'b1;
    for (int i = 0; i < band_log.size() && i < n_exp; i++)
      if (band_log[i] != exp_q[i] || ch_log[i] != lr || x_log[i] != x) ok = 1'b0;
    check("dispatch_seq", ok, 1'b1);
  endtask

  typedef struct {
    logic [15:0] x; logic lr; logic byp; logic [7:0] gain; logic [15:0] y; int lat;
    logic [15:0] exp_d; logic [4:0] exp_eq; int exp_cyc;
  } vec_t;
  vec_t vecs [8];

  initial begin
    logic [15:0] d, ed, x;
    logic [4:0]  eq, eeq;
    logic        lr, byp;
    int          c, dv0, ov0;

    vecs[0] = '{16'h7FFF, 1'b0, 1'b1, 8'h80, 16'h0000, 1, 16'h7FFF, 5'h00, 16};
    vecs[1] = '{16'h1234, 1'b1, 1'b0, 8'h80, 16'h0100, 1, 16'h0500, 5'h00, 31};
    vecs[2] = '{16'h0001, 1'b0, 1'b0, 8'hFF, 16'h7FFF, 1, 16'h7FFF, 5'h1F, 31};
    vecs[3] = '{16'h0002, 1'b1, 1'b0, 8'hFF, 16'h8000, 1, 16'h8000, 5'h1F, 31};
    vecs[4] = '{16'h8001, 1'b1, 1'b1, 8'h80, 16'h0100, 1, 16'h8001, 5'h00, 16};
    vecs[5] = '{16'h4321, 1'b0, 1'b0, 8'h80, 16'hFF00, 2, 16'hFB00, 5'h00, 36};
    vecs[6] = '{16'h00F0, 1'b1, 1'b0, 8'h40, 16'h0101, 3, 16'h0280, 5'h00, 41};
    vecs[7] = '{16'h0AAA, 1'b0, 1'b0, 8'hFF, 16'h4000, 1, 16'h7FFF, 5'h00, 31};

    reset = 1'b0; SFS = 1'b0; D = 1'b0; LR = 1'b0; bypass = 1'b0;
    gain_we = 1'b0; gain_addr = '0; gain_data = '0;
    for (int b = 0; b < 5; b++) begin gain_m[b] = 8'h80; stub_y[b] = '0; end

    // Reset state
    repeat (3) @(negedge SCK);
    check("rst_dout", D_out, 16'h0);
    check("rst_outs", {d_valid, core_start, busy, overrun, EQ_out}, 9'h0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    @(negedge SCK);
    check("rst_gains", gain_dbg, 40'h8080808080);

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      for (int b = 0; b < 5; b++) begin
        write_gain(3'(b), vecs[v].gain);
        stub_y[b] = vecs[v].y;
      end
      stub_lat = vecs[v].lat;
      start_sample(vecs[v].x, vecs[v].lr, vecs[v].byp);
      wait_result(d, eq, c);
      check($sformatf("tbl%0d_dout", v), d, vecs[v].exp_d);
      check($sformatf("tbl%0d_eq", v), eq, vecs[v].exp_eq);
      check($sformatf("tbl%0d_cycle", v), c, vecs[v].exp_cyc);
      check_dispatch(vecs[v].lr, vecs[v].x, vecs[v].byp);
    end

    // Unity gains for the hand sequences
    for (int b = 0; b < 5; b++) begin write_gain(3'(b), 8'h80); stub_y[b] = 16'h0100; end
    stub_lat = 1;

    // SFS during band processing: flagged, sample completes
    ov0 = ovr_cnt;
    start_sample(16'h0F0F, 1'b1, 1'b0);
    while (cyc < k_cyc + 19) @(negedge SCK);
    SFS = 1'b1; D = 1'b1;
    @(negedge SCK);
    SFS = 1'b0; D = 1'b0;
    wait_result(d, eq, c);
    check("ovr20_dout", d, 16'h0500);
    check("ovr20_cycle", c, 31);
    check("ovr20_pulses", ovr_cnt - ov0, 1);
    check_dispatch(1'b1, 16'h0F0F, 1'b0);

    // SFS during shift: capture restarts with the new word
    ov0 = ovr_cnt; dv0 = dv_cnt;
    send_bits(16'h1234, 8, 1'b0, 1'b1);
    start_sample(16'h5678, 1'b0, 1'b1);
    wait_result(d, eq, c);
    check("ovr8_dout", d, 16'h5678);
    check("ovr8_cycle", c, 16);
    check("ovr8_pulses", ovr_cnt - ov0, 1);
    check("ovr8_dvalid_count", dv_cnt - dv0, 1);

    // Gain write mid-sample only affects the next sample
    start_sample(16'h2222, 1'b0, 1'b0);
    while (cyc < k_cyc + 17) @(negedge SCK);
    gain_we = 1'b1; gain_addr = 3'd2; gain_data = 8'h00;
    @(negedge SCK);
    gain_we = 1'b0; gain_m[2] = 8'h00;
    wait_result(d, eq, c);
    check("gw_this_sample", d, 16'h0500);
    start_sample(16'h3333, 1'b0, 1'b0);
    wait_result(d, eq, c);
    check("gw_next_sample", d, 16'h0400);

    // Out-of-range gain address is ignored
    write_gain(3'd6, 8'h11);
    write_gain(3'd5, 8'h22);
    check("gain_addr_ignored", gain_dbg, gains_packed());

    // Reset while waiting on the core
    stub_lat = 4;
    start_sample(16'h1111, 1'b0, 1'b0);
    for (int i = 0; i < 20 && state_dbg != ST_WAIT; i++) @(negedge SCK);
    check("reach_wait", state_dbg, ST_WAIT);
    check("busy_in_wait", busy, 1'b1);
    dv0 = dv_cnt;
    reset = 1'b0;
    #1;
    check("midrst_outs", {d_valid, core_start, busy, overrun, EQ_out, D_out}, 25'h0);
    check("midrst_state", state_dbg, ST_IDLE);
    repeat (2) @(negedge SCK);
    reset = 1'b1;
    for (int b = 0; b < 5; b++) gain_m[b] = 8'h80;
    repeat (10) @(negedge SCK);
    check("midrst_no_dvalid", dv_cnt - dv0, 0);
    check("midrst_gains", gain_dbg, gains_packed());
    stub_lat = 1;
    start_sample(16'h4444, 1'b1, 1'b0);
    wait_result(d, eq, c);
    check("after_rst_dout", d, 16'h0500);
    check("after_rst_cycle", c, 31);

    // Randomized samples against the reference model
    for (int i = 0; i < 30; i++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) write_gain(3'($urandom_range(0, 7)), 8'($urandom));
      check("rnd_gain_readback", gain_dbg, gains_packed());
      stub_lat = $urandom_range(1, 3);
      for (int b = 0; b < 5; b++)
        stub_y[b] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
      x   = 16'($urandom);
      lr  = 1'($urandom);
      byp = ($urandom_range(0, 3) == 0);
      start_sample(x, lr, byp);
      model(x, byp, ed, eeq);
      wait_result(d, eq, c);
      check("rnd_dout", d, ed);
      check("rnd_eq", eq, eeq);
      check("rnd_cycle", c, byp ? 16 : 16 + 5 * (2 + stub_lat));
      check_dispatch(lr, x, byp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
